// File: rtl/local_inject_ctrl_if.sv
// Injection-port bundle: NI-side offer, router-side channel occupancy, and grant/status back.
// master = NI/router driver side, slave = the injection controller.
interface local_inject_ctrl_if #(
  parameter int NUM_CHANNEL = 5,
  parameter int FLIT_W      = 64,
  parameter int FIFO_DEPTH  = 4
);
  logic [NUM_CHANNEL-1:0]        validIn;
  logic                          inj_valid;
  logic [FLIT_W-1:0]             inj_flit;
  logic                          inj_ready;
  logic [NUM_CHANNEL-1:0]        grant;
  logic [FLIT_W-1:0]             inj_flit_out;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;
  logic                          starve;

  modport master (
    output validIn, inj_valid, inj_flit,
    input  inj_ready, grant, inj_flit_out, fifo_count, starve
  );

  modport slave (
    input  validIn, inj_valid, inj_flit,
    output inj_ready, grant, inj_flit_out, fifo_count, starve
  );
endinterface

// File: rtl/local_inject_ctrl.sv
// Local-injection controller: queues NI flits, grants the head to the first idle channel (1-cycle head latency, no bypass).
// Backpressure: inj_ready = ~full; optional rotating priority via INJ_ROUND_ROBIN_EN, else fixed lowest-index priority.
module local_inject_ctrl #(
  parameter int NUM_CHANNEL   = 5,
  parameter int FLIT_W        = 64,
  parameter int FIFO_DEPTH    = 4,
  parameter int STARVE_THRESH = 8,
  parameter int CNT_W         = 4
) (
  input  logic              clk,
  input  logic              reset,
  local_inject_ctrl_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int CH_W  = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;

  localparam logic [OCC_W-1:0] DEPTH_V  = OCC_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] THRESH_V = CNT_W'(STARVE_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CHANNEL - 1);

  logic [FLIT_W-1:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       starve_cnt_q, starve_cnt_d;
  logic                   starve_q, starve_d;

  logic                   fifo_empty;
  logic                   fifo_full;
  logic                   push;
  logic                   pop;
  logic [CH_W-1:0]        prio;
  logic [CH_W-1:0]        gnt_idx;
  logic                   gnt_found;
  logic [NUM_CHANNEL-1:0] grant;
  int                     idx;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_V);
  assign push       = bus.inj_valid && !fifo_full;
  assign pop        = |grant;

`ifdef INJ_ROUND_ROBIN_EN
  logic [CH_W-1:0] prio_q, prio_d;

  always_comb begin
    prio_d = prio_q;
    if (pop) begin
      prio_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prio_q <= '0;
    else       prio_q <= prio_d;
  end

  assign prio = prio_q;
`else
  assign prio = '0;
`endif

  // Scan channels starting at the priority pointer, wrapping once; first idle channel wins.
  always_comb begin
    gnt_idx   = '0;
    gnt_found = 1'b0;
    grant     = '0;
    idx       = 0;
    if (!fifo_empty) begin
      for (int i = 0; i < NUM_CHANNEL; i++) begin
        idx = int'(prio) + i;
        if (idx >= NUM_CHANNEL) idx = idx - NUM_CHANNEL;
        if (!gnt_found && !bus.validIn[idx]) begin
          gnt_found = 1'b1;
          gnt_idx   = CH_W'(idx);
        end
      end
    end
    if (gnt_found) grant = NUM_CHANNEL'(1) << gnt_idx;
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Non-empty without a pop means the head was blocked this cycle.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (pop || fifo_empty) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != CNT_MAX) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
    starve_d = (starve_cnt_d >= THRESH_V);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  // Storage needs no reset: occupancy is governed entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.inj_flit;
  end

  assign bus.inj_ready    = !fifo_full;
  assign bus.grant        = grant;
  assign bus.inj_flit_out = mem_q[rd_ptr_q];
  assign bus.fifo_count   = count_q;
  assign bus.starve       = starve_q;

endmodule

// File: tb/tb_local_inject_ctrl.sv
// Directed bench for local_inject_ctrl; a negedge monitor checks every grant against a queue of expected (flit, grant) pairs.
module tb_local_inject_ctrl;
  localparam int NC = 5;
  localparam int FW = 64;
  localparam int FD = 4;

  typedef struct {
    logic [FW-1:0] flit;
    logic [NC-1:0] gnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  exp_t e;

  local_inject_ctrl_if #(.NUM_CHANNEL(NC), .FLIT_W(FW), .FIFO_DEPTH(FD)) bus ();

  local_inject_ctrl #(
    .NUM_CHANNEL(NC), .FLIT_W(FW), .FIFO_DEPTH(FD), .STARVE_THRESH(8), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    bus.validIn   = '1;
    bus.inj_valid = 1'b0;
    bus.inj_flit  = '0;
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic expect_pop(input logic [FW-1:0] f, input logic [NC-1:0] g);
    exp_t x;
    x.flit = f;
    x.gnt  = g;
    exp_q.push_back(x);
  endtask

  task automatic push_flit(input logic [FW-1:0] f);
    bus.inj_valid = 1'b1;
    bus.inj_flit  = f;
    tick();
    bus.inj_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (!reset && (|bus.grant)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant: got grant %b with flit %0h, none expected", bus.grant, bus.inj_flit_out);
      end else begin
        e = exp_q.pop_front();
        chk("mon_grant", 64'(bus.grant), 64'(e.gnt));
        chk("mon_flit", bus.inj_flit_out, e.flit);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.validIn   = '1;
    bus.inj_valid = 1'b0;
    bus.inj_flit  = '0;
    #3;
    chk("rst_count", 64'(bus.fifo_count), 64'd0);
    chk("rst_ready", 64'(bus.inj_ready), 64'd1);
    chk("rst_grant", 64'(bus.grant), 64'd0);
    chk("rst_starve", 64'(bus.starve), 64'd0);
    tick();
    reset = 1'b0;

    // Test 1: reset mid-queue with three flits and starve asserted.
    tick();
    apply_reset();
    push_flit(64'hF0);
    push_flit(64'hF1);
    push_flit(64'hF2);
    for (int k = 0; k < 8; k++) tick();
    chk("t1_count_before", 64'(bus.fifo_count), 64'd3);
    chk("t1_starve_before", 64'(bus.starve), 64'd1);
    bus.validIn = '0;
    reset = 1'b1;
    #1;
    chk("t1_count", 64'(bus.fifo_count), 64'd0);
    chk("t1_grant", 64'(bus.grant), 64'd0);
    chk("t1_starve", 64'(bus.starve), 64'd0);
    chk("t1_ready", 64'(bus.inj_ready), 64'd1);
    #1;
    reset = 1'b0;
    bus.validIn = '1;

    // Test 2: head latency and first-idle grant.
    tick();
    apply_reset();
    bus.validIn   = 5'b00011;
    bus.inj_valid = 1'b1;
    bus.inj_flit  = 64'hAAAA;
    #1;
    chk("t2_no_grant_push_cycle", 64'(bus.grant), 64'd0);
    expect_pop(64'hAAAA, 5'b00100);
    tick();
    bus.inj_flit = 64'hBBBB;
    tick();
    bus.inj_valid = 1'b0;
    bus.validIn   = 5'b11111;
    #1;
    chk("t2_head_b", bus.inj_flit_out, 64'hBBBB);
    chk("t2_count_b", 64'(bus.fifo_count), 64'd1);
    bus.validIn = 5'b11011;
    expect_pop(64'hBBBB, 5'b00100);
    tick();
    chk("t2_count_end", 64'(bus.fifo_count), 64'd0);

    // Test 3: fill while blocked, full backpressure, starvation threshold.
    apply_reset();
    bus.inj_valid = 1'b1;
    bus.inj_flit  = 64'hC0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      bus.inj_flit = (k < 4) ? 64'hC0 + 64'(k) : 64'hDEAD;
      tick();
      chk($sformatf("t3_starve_k%0d", k), 64'(bus.starve), (k >= 8) ? 64'd1 : 64'd0);
    end
    chk("t3_count_full", 64'(bus.fifo_count), 64'd4);
    chk("t3_ready_full", 64'(bus.inj_ready), 64'd0);
    bus.inj_valid = 1'b0;
    bus.validIn   = 5'b11110;
    expect_pop(64'hC0, 5'b00001);
    tick();
    chk("t3_starve_clr", 64'(bus.starve), 64'd0);
    chk("t3_count_pop", 64'(bus.fifo_count), 64'd3);
    for (int k = 1; k < 4; k++) expect_pop(64'hC0 + 64'(k), 5'b00001);
    for (int k = 1; k < 4; k++) tick();
    chk("t3_count_end", 64'(bus.fifo_count), 64'd0);
    chk("t3_starve_end", 64'(bus.starve), 64'd0);

    // Test 4: simultaneous push/pop at count 2, repeated across pointer wrap.
    apply_reset();
    push_flit(64'hD00);
    push_flit(64'hD01);
    chk("t4_count_init", 64'(bus.fifo_count), 64'd2);
    bus.validIn   = 5'b11110;
    bus.inj_valid = 1'b1;
    for (int k = 0; k < 11; k++) begin
      bus.inj_flit = 64'hD00 + 64'(k + 2);
      expect_pop(64'hD00 + 64'(k), 5'b00001);
      tick();
      chk($sformatf("t4_count_k%0d", k), 64'(bus.fifo_count), 64'd2);
    end
    bus.inj_valid = 1'b0;
    expect_pop(64'hD00 + 64'd11, 5'b00001);
    expect_pop(64'hD00 + 64'd12, 5'b00001);
    tick();
    tick();
    chk("t4_count_end", 64'(bus.fifo_count), 64'd0);

    // Test 5: priority pointer behaviour with all channels idle.
    apply_reset();
    push_flit(64'hE0);
    push_flit(64'hE1);
    push_flit(64'hE2);
    bus.validIn = 5'b00000;
`ifdef INJ_ROUND_ROBIN_EN
    expect_pop(64'hE0, 5'b00001);
    expect_pop(64'hE1, 5'b00010);
    expect_pop(64'hE2, 5'b00100);
`else
    expect_pop(64'hE0, 5'b00001);
    expect_pop(64'hE1, 5'b00001);
    expect_pop(64'hE2, 5'b00001);
`endif
    tick();
    tick();
    tick();
    chk("t5_count_end", 64'(bus.fifo_count), 64'd0);

    tick();
    chk("all_expected_grants_seen", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
